// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: connects a serial line source to the receiver's
// character output. The line side (rx, rx_en) is driven by the master.
// The receiver is the slave and drives the character, strobe, error
// flags and busy.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 rx;
  logic                 rx_en;
  logic [DATA_BITS-1:0] data;
  logic                 done;
  logic                 err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    output rx,
    output rx_en,
    input  data,
    input  done,
    input  err,
    input  parity_err,
    input  busy
  );

  modport slave (
    input  rx,
    input  rx_en,
    output data,
    output done,
    output err,
    output parity_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with an oversampling tick
// generator, configurable width, parity and stop bits, false-start
// rejection and separate framing and parity error flags.
//
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN.
// - When defined, every sample point takes a 2-of-3 majority vote of the
//   synchronised line at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and
//   OVERSAMPLE/2+1.
// - When undefined, each sample point is a single sample at tick
//   OVERSAMPLE/2.
module uart_rx_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_param_if.slave bus
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW      = $clog2(OVERSAMPLE + 1);
  localparam int BW      = $clog2(DATA_BITS + 1);

  // First decision point after the start edge. The vote needs one
  // extra tick so that it can see the sample after mid-bit.
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int DEC_START = OVERSAMPLE / 2 + 1;
`else
  localparam int DEC_START = OVERSAMPLE / 2;
`endif

  localparam logic [CW-1:0] DEC_START_C = CW'(DEC_START);
  localparam logic [CW-1:0] DEC_BIT_C   = CW'(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_LAST    = DW'(DIV - 1);
  localparam logic [BW-1:0] DATA_LAST   = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST   = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_s_q, rx_prev_q;
  logic [DW-1:0]          div_cnt_q, div_cnt_d;
  logic [CW-1:0]          os_cnt_q, os_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_acc_q, par_acc_d;
  logic                   perr_acc_q, perr_acc_d;
  logic                   ferr_acc_q, ferr_acc_d;
  logic                   brk_q, brk_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   perr_q, perr_d;

  logic                   tick;
  logic                   decide;
  logic                   sample_bit;
  logic                   stop_low;
  logic [CW-1:0]          os_next;

  assign tick    = (div_cnt_q == DIV_LAST);
  assign os_next = os_cnt_q + 1'b1;
  assign decide  = tick &&
                   (os_next == ((state_q == S_START) ? DEC_START_C : DEC_BIT_C));

  // Two-flop synchroniser on the line plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;

  // Keep the line value seen on the two previous ticks for the vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else if (tick) begin
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign sample_bit = (hist_q[1] & hist_q[0]) |
                      (hist_q[1] & rx_s_q)    |
                      (hist_q[0] & rx_s_q);
`else
  assign sample_bit = rx_s_q;
`endif

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      brk_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_acc_q  <= par_acc_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      brk_q      <= brk_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      perr_q     <= perr_d;
    end
  end

  // Next-state logic: tick generation, frame sequencing and the result strobe.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    // A break lock clears once the line is seen high.
    brk_d      = brk_q & ~rx_s_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    perr_d     = 1'b0;
    stop_low   = ferr_acc_q | ~sample_bit;

    if (state_q == S_IDLE) begin
      if (bus.rx_en && !brk_q && rx_prev_q && !rx_s_q) begin
        // Restart the tick generator so sampling is phase-aligned to the edge.
        state_d   = S_START;
        div_cnt_d = '0;
        os_cnt_d  = '0;
      end
    end else if (!bus.rx_en) begin
      state_d = S_IDLE;
    end else if (tick) begin
      os_cnt_d = os_next;
      if (decide) begin
        os_cnt_d = '0;
        case (state_q)
          S_START: begin
            if (sample_bit) begin
              state_d = S_IDLE;
            end else begin
              state_d    = S_DATA;
              bit_cnt_d  = '0;
              par_acc_d  = 1'b0;
              perr_acc_d = 1'b0;
              ferr_acc_d = 1'b0;
            end
          end
          S_DATA: begin
            shift_d   = {sample_bit, shift_q[DATA_BITS-1:1]};
            par_acc_d = par_acc_q ^ sample_bit;
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = '0;
              state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          S_PARITY: begin
            // Odd parity wants an odd total of ones; even parity wants even.
            perr_acc_d = (PARITY == 1) ? ~(par_acc_q ^ sample_bit)
                                       :  (par_acc_q ^ sample_bit);
            state_d    = S_STOP;
          end
          S_STOP: begin
            if (bit_cnt_q == STOP_LAST) begin
              state_d = S_IDLE;
              data_d  = shift_q;
              done_d  = 1'b1;
              err_d   = stop_low;
              perr_d  = perr_acc_q;
              brk_d   = ~sample_bit;
            end else begin
              bit_cnt_d  = bit_cnt_q + 1'b1;
              ferr_acc_d = stop_low;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.parity_err = perr_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds configurable character width, parity and stop bits, an internal oversampling baud-tick generator, false-start rejection and separate framing/parity error flags. Sits between the serial input pin and the byte-consuming logic, presenting each received character as a one-cycle `done` strobe with `data` held stable until the next character.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit; even, 8..32.
- `DATA_BITS`, 8: character width, 5..9.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idle high.
- `rx_en`  in  1  receive enable.
- `data`  out  DATA_BITS  last received character, LSB-first on the line.
- `done`  out  1  one-cycle strobe: character complete.
- `err`  out  1  framing error, valid only with `done`.
- `parity_err`  out  1  parity mismatch, valid only with `done`; always 0 when PARITY=0.
- `busy`  out  1  frame in progress.

## Operation
- `rx` passes through a 2-flop synchroniser; all decisions use the synchronised value.
- Tick generator: divisor DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncated, minimum 1; free-running counter 0..DIV-1 emits a one-cycle `tick` on wrap. Restarted at start-edge detection so sampling phase is aligned to the edge.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `busy`=0. Start edge = synchronised `rx` high then low while `rx_en`=1 -> START.
- START: at tick OVERSAMPLE/2 sample; if high -> IDLE (false start, no `done`, no flags); if low -> DATA, tick count reset.
- DATA: sample every OVERSAMPLE ticks (mid-bit), shift in LSB first; after DATA_BITS samples -> PARITY if PARITY≠0, else STOP.
- PARITY: one mid-bit sample; `parity_err` = received bit ≠ expected (odd: total ones including parity bit odd; even: even).
- STOP: STOP_BITS mid-bit samples; `err`=1 if any is low. After the last stop sample: `data` updated, `done`=1 for one cycle together with `err`/`parity_err`, -> IDLE.
- Framing error still delivers the character (`done`=1, `data` updated, `err`=1).
- After a frame whose last stop sample was low (break), no new start is accepted until the synchronised line has been seen high for at least one cycle.
- `rx_en` low in any state other than IDLE: abort to IDLE next cycle, no `done`, `data` unchanged.
- `rst`: all state to IDLE, counters to 0, synchroniser to 1.

## Timing
- Reset values: `data`=0, `done`=0, `err`=0, `parity_err`=0, `busy`=0.
- `busy` rises the cycle after start-edge detection; falls in the same cycle `done` is asserted (`busy`=0 while `done`=1).
- `err`/`parity_err` are 0 in every cycle `done`=0.
- Latency: `done` asserts N*OVERSAMPLE*DIV - (OVERSAMPLE/2)*DIV + 3 clk cycles (±1) after the falling edge on `rx`, with N = 1+DATA_BITS+(PARITY≠0)+STOP_BITS.
- `data` changes only in the `done` cycle; holds otherwise.
- Back-to-back frames (next start bit immediately after the last stop bit) must be received without loss.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined: each sample point (start, data, parity, stop) takes the 2-of-3 majority of the synchronised line at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1; the decision is made at tick OVERSAMPLE/2+1, adding one tick to latency.
- Undefined: a single sample at tick OVERSAMPLE/2.

## Test plan
Bench parameters: CLK_FREQ=1_600_000, BAUD=100_000, OVERSAMPLE=16 (DIV=1, 16 clk/bit).
- 8N1, send 0x5A -> one `done` pulse, `data`=0x5A, `err`=0, `parity_err`=0; `busy` high during the frame and low in the `done` cycle.
- DATA_BITS=7, PARITY=2, send 0x35 with correct parity bit 0 -> `data`=0x35, `parity_err`=0; resend with parity bit 1 -> `parity_err`=1 with `done`.
- STOP_BITS=2, send 0xA5 with second stop bit low -> `done`=1, `data`=0xA5, `err`=1; hold line low 40 bits -> no further `done` until the line returns high and a new start bit arrives.
- Glitch: `rx` low for 4 clk in IDLE -> no `done`, `busy` returns to 0 within 10 clk.
- Deassert `rx_en` after bit 3 of 0xFF -> no `done`, `data` keeps its previous value; the next 0x0F frame with `rx_en`=1 is received correctly.
- Assert `rst` mid-frame for 1 cycle -> all outputs 0 next cycle; the following 0xC3 frame is received correctly; repeat with `UART_RX_MAJORITY_VOTE_EN` defined and a 1-clk glitch injected at mid-bit -> `data` still 0xC3.
